// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the pipelined slice ALU.
//   alu_op_t        2-bit operation code carried down the pipeline
//   OP_AND/OP_OR    bitwise operations on a and (optionally inverted) b
//   OP_ADD          a + bb + cin, modulo 2^WIDTH
//   OP_SLT          set-less-than; caller supplies binv=1, cin=1
//   op_uses_adder   true for the operations whose flags come from the adder
package alu_pkg;

  typedef logic [1:0] alu_op_t;

  localparam alu_op_t OP_AND = 2'b00;
  localparam alu_op_t OP_OR  = 2'b01;
  localparam alu_op_t OP_ADD = 2'b10;
  localparam alu_op_t OP_SLT = 2'b11;

  function automatic logic op_uses_adder(input alu_op_t op);
    return (op == OP_ADD) || (op == OP_SLT);
  endfunction

endpackage

// File: rtl/alu_slice.sv
// alu_slice: combinational SLICE-bit ALU slice.
//   a_i, b_i  operand bits of this slice
//   binv_i    invert b_i before any operation
//   cin_i     carry into the slice LSB
//   op_i      operation code (AND / OR / ADD / SLT)
//   res_o     AND, OR or sum bits depending on op_i (SLT passes the sum)
//   cout_o    carry out of the slice MSB
//   cmsb_o    carry into the slice MSB (for signed overflow detection)
module alu_slice
  import alu_pkg::*;
#(
  parameter int SLICE = 8
) (
  input  logic [SLICE-1:0] a_i,
  input  logic [SLICE-1:0] b_i,
  input  logic             binv_i,
  input  logic             cin_i,
  input  alu_op_t          op_i,
  output logic [SLICE-1:0] res_o,
  output logic             cout_o,
  output logic             cmsb_o
);

  logic [SLICE-1:0] bb;
  logic [SLICE:0]   sum;

  always_comb begin
    bb  = b_i ^ {SLICE{binv_i}};
    sum = {1'b0, a_i} + {1'b0, bb} + {{SLICE{1'b0}}, cin_i};
    case (op_i)
      OP_AND:  res_o = a_i & bb;
      OP_OR:   res_o = a_i | bb;
      default: res_o = sum[SLICE-1:0];
    endcase
  end

  assign cout_o = sum[SLICE];
  // The carry into the MSB is recovered from the MSB sum bit and its addends.
  assign cmsb_o = sum[SLICE-1] ^ a_i[SLICE-1] ^ bb[SLICE-1];

endmodule

// File: rtl/alu_pipe_nbit.sv
// alu_pipe_nbit: WIDTH-bit AND/OR/ADD/SLT ALU split into WIDTH/SLICE
// registered slice stages with the carry rippling stage to stage.
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   in_valid / in_ready  operand handshake; in_ready = !out_valid || out_ready
//   a, b, binv, cin, op  operands, invert-b, carry-in, operation code
//   out_valid/out_ready  result handshake; whole pipe stalls when blocked
//   result, zero         ALU result and result == 0
//   cout, ovf            MSB carry out and signed overflow (ADD/SLT only)
module alu_pipe_nbit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             binv,
  input  logic             cin,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             cout,
  output logic             ovf
);

  localparam int STAGES = (WIDTH / SLICE < 1) ? 1 : WIDTH / SLICE;
  localparam int L      = STAGES - 1;

  if (WIDTH % SLICE != 0) begin : g_cfg_err
    $error("alu_pipe_nbit: WIDTH must be a multiple of SLICE");
  end

  // Stage registers: entry s holds the state after slice s has been computed.
  logic             vld_q  [STAGES];
  logic [WIDTH-1:0] a_q    [STAGES];
  logic [WIDTH-1:0] b_q    [STAGES];
  logic [WIDTH-1:0] res_q  [STAGES];
  logic [WIDTH-1:0] res_d  [STAGES];
  logic             binv_q [STAGES];
  logic             c_q    [STAGES];
  logic             cmsb_q [STAGES];
  alu_op_t          op_q   [STAGES];

  logic [SLICE-1:0] sl_a    [STAGES];
  logic [SLICE-1:0] sl_b    [STAGES];
  logic [SLICE-1:0] sl_res  [STAGES];
  logic             sl_binv [STAGES];
  logic             sl_cin  [STAGES];
  logic             sl_cout [STAGES];
  logic             sl_cmsb [STAGES];
  alu_op_t          sl_op   [STAGES];

  logic advance;

  assign out_valid = vld_q[L];
  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance;

  // Slice 0 works on the live inputs; slice s works on stage s-1's registers.
  for (genvar s = 0; s < STAGES; s++) begin : g_slice
    if (s == 0) begin : g_head
      assign sl_a[0]    = a[SLICE-1:0];
      assign sl_b[0]    = b[SLICE-1:0];
      assign sl_binv[0] = binv;
      assign sl_cin[0]  = cin;
      assign sl_op[0]   = op;
    end else begin : g_body
      assign sl_a[s]    = a_q[s-1][s*SLICE +: SLICE];
      assign sl_b[s]    = b_q[s-1][s*SLICE +: SLICE];
      assign sl_binv[s] = binv_q[s-1];
      assign sl_cin[s]  = c_q[s-1];
      assign sl_op[s]   = op_q[s-1];
    end

    alu_slice #(.SLICE(SLICE)) u_slice (
      .a_i    (sl_a[s]),
      .b_i    (sl_b[s]),
      .binv_i (sl_binv[s]),
      .cin_i  (sl_cin[s]),
      .op_i   (sl_op[s]),
      .res_o  (sl_res[s]),
      .cout_o (sl_cout[s]),
      .cmsb_o (sl_cmsb[s])
    );
  end

  // Merge each new slice result into the partial result travelling down.
  always_comb begin
    for (int s = 0; s < STAGES; s++) begin
      res_d[s] = (s == 0) ? '0 : res_q[(s == 0) ? 0 : s - 1];
      res_d[s][s*SLICE +: SLICE] = sl_res[s];
    end
  end

  // Stage boundary: every stage register advances together or holds together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < STAGES; s++) begin
        vld_q[s]  <= 1'b0;
        a_q[s]    <= '0;
        b_q[s]    <= '0;
        res_q[s]  <= '0;
        binv_q[s] <= 1'b0;
        c_q[s]    <= 1'b0;
        cmsb_q[s] <= 1'b0;
        op_q[s]   <= OP_AND;
      end
    end else if (advance) begin
      vld_q[0] <= in_valid;
      if (in_valid) begin
        a_q[0]    <= a;
        b_q[0]    <= b;
        binv_q[0] <= binv;
        op_q[0]   <= op;
        c_q[0]    <= sl_cout[0];
        cmsb_q[0] <= sl_cmsb[0];
        res_q[0]  <= res_d[0];
      end
      for (int s = 1; s < STAGES; s++) begin
        vld_q[s] <= vld_q[s-1];
        if (vld_q[s-1]) begin
          a_q[s]    <= a_q[s-1];
          b_q[s]    <= b_q[s-1];
          binv_q[s] <= binv_q[s-1];
          op_q[s]   <= op_q[s-1];
          c_q[s]    <= sl_cout[s];
          cmsb_q[s] <= sl_cmsb[s];
          res_q[s]  <= res_d[s];
        end
      end
    end
  end

  // Output stage: flags and SLT mux from the last register only.
  logic use_add;

  always_comb begin
    use_add = op_uses_adder(op_q[L]);
    ovf     = use_add & (cmsb_q[L] ^ c_q[L]);
    cout    = use_add & c_q[L];
    result  = res_q[L];
    if (op_q[L] == OP_SLT) begin
      result = {{(WIDTH-1){1'b0}}, res_q[L][WIDTH-1] ^ ovf};
    end
    zero = (result == '0);
  end

endmodule

// File: tb/tb_alu_pipe_nbit.sv
module tb_alu_pipe_nbit;
  import alu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;

  // 32-bit, 4-stage instance
  logic        in_valid = 1'b0, in_ready, binv = 1'b0, cin = 1'b0;
  logic        out_valid, out_ready = 1'b1, zero, cout, ovf;
  logic [1:0]  op = OP_AND;
  logic [31:0] a = '0, b = '0, result;

  // 8-bit, single-stage instance
  logic        in_valid8 = 1'b0, in_ready8, binv8 = 1'b0, cin8 = 1'b0;
  logic        out_valid8, out_ready8 = 1'b1, zero8, cout8, ovf8;
  logic [1:0]  op8 = OP_AND;
  logic [7:0]  a8 = '0, b8 = '0, result8;

  int tests = 0;
  int fails = 0;
  bit timed_out;

  alu_pipe_nbit #(.WIDTH(32), .SLICE(8)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .binv(binv), .cin(cin), .op(op),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .cout(cout), .ovf(ovf)
  );

  alu_pipe_nbit #(.WIDTH(8), .SLICE(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .binv(binv8), .cin(cin8), .op(op8),
    .out_valid(out_valid8), .out_ready(out_ready8), .result(result8),
    .zero(zero8), .cout(cout8), .ovf(ovf8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] ta, input logic [31:0] tb_v,
                       input logic tbinv, input logic tcin, input logic [1:0] top);
    a = ta; b = tb_v; binv = tbinv; cin = tcin; op = top; in_valid = 1'b1;
  endtask

  // Issue one operation and wait (bounded) for it to reach the outputs.
  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v,
                        input logic tbinv, input logic tcin, input logic [1:0] top);
    int n;
    drive(ta, tb_v, tbinv, tcin, top);
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 10) begin
      tick();
      n++;
    end
    timed_out = !out_valid;
  endtask

  // Independent 8-bit reference: {result, cout, ovf, zero}
  function automatic logic [10:0] ref8(input logic [7:0] ra, input logic [7:0] rb,
                                       input logic rbinv, input logic rcin,
                                       input logic [1:0] rop);
    logic [7:0] bb, r;
    logic [8:0] s9;
    logic c, v;
    bb = rbinv ? ~rb : rb;
    s9 = {1'b0, ra} + {1'b0, bb} + {8'd0, rcin};
    c  = s9[8];
    v  = (ra[7] == bb[7]) && (s9[7] != ra[7]);
    case (rop)
      OP_AND:  begin r = ra & bb; c = 1'b0; v = 1'b0; end
      OP_OR:   begin r = ra | bb; c = 1'b0; v = 1'b0; end
      OP_ADD:  r = s9[7:0];
      default: r = (s9[7] != v) ? 8'd1 : 8'd0;
    endcase
    return {r, c, v, (r == 8'd0)};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick(); tick();
    tests++;
    if ({out_valid, result, zero, cout, ovf} !== {1'b0, 32'h0, 1'b1, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL reset_state: got v=%b r=%h z=%b c=%b o=%b, need v=0 r=0 z=1 c=0 o=0",
               out_valid, result, zero, cout, ovf);
    end
    tests++;
    if ({out_valid8, result8, zero8} !== {1'b0, 8'h00, 1'b1}) begin
      fails++;
      $display("FAIL reset_state8: got v=%b r=%h z=%b, need v=0 r=00 z=1",
               out_valid8, result8, zero8);
    end
    rst = 1'b0;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_in_ready: got %b need 1", in_ready);
    end
    tick();
  endtask

  task automatic test_add_carry();
    drive(32'h00FF_FFFF, 32'h0000_0001, 1'b0, 1'b0, OP_ADD);
    tick();
    in_valid = 1'b0;
    for (int e = 1; e < 4; e++) begin
      tests++;
      if (out_valid !== 1'b0) begin
        fails++;
        $display("FAIL add_early_valid: after edge %0d got out_valid=%b need 0", e, out_valid);
      end
      tick();
    end
    tests++;
    if ({out_valid, result, cout, ovf, zero} !== {1'b1, 32'h0100_0000, 1'b0, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL add_carry: got v=%b r=%h c=%b o=%b z=%b, need v=1 r=01000000 c=0 o=0 z=0",
               out_valid, result, cout, ovf, zero);
    end
    tick();
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL add_duplicate: got out_valid=%b need 0", out_valid);
    end
  endtask

  task automatic test_sub();
    run_op(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, OP_ADD);
    tests++;
    if (timed_out || {result, cout, ovf, zero} !== {32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL sub_ovf: got to=%b r=%h c=%b o=%b z=%b, need r=7fffffff c=1 o=1 z=0",
               timed_out, result, cout, ovf, zero);
    end
    tick();
    run_op(32'h1234_5678, 32'h1234_5678, 1'b1, 1'b1, OP_ADD);
    tests++;
    if (timed_out || {result, cout, ovf, zero} !== {32'h0, 1'b1, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL sub_zero: got to=%b r=%h c=%b o=%b z=%b, need r=0 c=1 o=0 z=1",
               timed_out, result, cout, ovf, zero);
    end
    tick();
  endtask

  task automatic test_slt();
    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b1, OP_SLT);
    tests++;
    if (timed_out || {result, ovf, zero} !== {32'h1, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL slt_neg: got to=%b r=%h o=%b z=%b, need r=1 o=0 z=0",
               timed_out, result, ovf, zero);
    end
    tick();
    run_op(32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 1'b1, OP_SLT);
    tests++;
    if (timed_out || {result, cout, ovf, zero} !== {32'h0, 1'b0, 1'b1, 1'b1}) begin
      fails++;
      $display("FAIL slt_ovf: got to=%b r=%h c=%b o=%b z=%b, need r=0 c=0 o=1 z=1",
               timed_out, result, cout, ovf, zero);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int n;
    drive(32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, 1'b0, OP_AND);
    tick();
    drive(32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, 1'b0, OP_OR);
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 10) begin
      tick();
      n++;
    end
    out_ready = 1'b0;
    // Garbage offered during the stall must be ignored.
    drive(32'hDEAD_BEEF, 32'h1111_1111, 1'b0, 1'b0, OP_ADD);
    #1;
    for (int k = 0; k < 3; k++) begin
      tests++;
      if ({out_valid, in_ready, result, cout, ovf} !== {1'b1, 1'b0, 32'hF000_F000, 1'b0, 1'b0}) begin
        fails++;
        $display("FAIL stall_hold_%0d: got v=%b rdy=%b r=%h c=%b o=%b, need v=1 rdy=0 r=f000f000",
                 k, out_valid, in_ready, result, cout, ovf);
      end
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    tests++;
    if ({out_valid, result, zero} !== {1'b1, 32'hFFF0_FFF0, 1'b0}) begin
      fails++;
      $display("FAIL b2b_or: got v=%b r=%h z=%b, need v=1 r=fff0fff0 z=0",
               out_valid, result, zero);
    end
    tick();
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL b2b_extra: got out_valid=%b r=%h need 0", out_valid, result);
    end
  endtask

  task automatic test_reset_midflight();
    drive(32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0, OP_ADD);
    tick();
    drive(32'hFFFF_0000, 32'h00FF_FF00, 1'b0, 1'b0, OP_OR);
    tick();
    drive(32'h1234_0000, 32'h0000_5678, 1'b0, 1'b0, OP_ADD);
    tick();
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    tests++;
    if ({out_valid, result, zero} !== {1'b0, 32'h0, 1'b1}) begin
      fails++;
      $display("FAIL midflight_in_reset: got v=%b r=%h z=%b, need v=0 r=0 z=1",
               out_valid, result, zero);
    end
    tick(); tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      tests++;
      if (out_valid !== 1'b0) begin
        fails++;
        $display("FAIL midflight_stale_%0d: got out_valid=%b r=%h need 0", k, out_valid, result);
      end
    end
  endtask

  task automatic test_single_stage();
    a8 = 8'h7F; b8 = 8'h01; binv8 = 1'b0; cin8 = 1'b0; op8 = OP_ADD; in_valid8 = 1'b1;
    tick();
    in_valid8 = 1'b0;
    tests++;
    if ({out_valid8, result8, cout8, ovf8, zero8} !== {1'b1, 8'h80, 1'b0, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL s1_add_ovf: got v=%b r=%h c=%b o=%b z=%b, need v=1 r=80 c=0 o=1 z=0",
               out_valid8, result8, cout8, ovf8, zero8);
    end
    tick();
  endtask

  task automatic test_stream8();
    logic [10:0] q[$];
    logic [10:0] exp_v;
    int acc = 0;
    int cyc = 0;
    while ((acc < 1000 || q.size() > 0) && cyc < 20000) begin
      out_ready8 = ($urandom_range(0, 3) != 0);
      if (acc < 1000 && $urandom_range(0, 3) != 0) begin
        a8 = 8'($urandom); b8 = 8'($urandom); binv8 = 1'($urandom);
        cin8 = 1'($urandom); op8 = 2'($urandom); in_valid8 = 1'b1;
      end else begin
        in_valid8 = 1'b0;
      end
      #1;
      if (out_valid8 && out_ready8) begin
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL stream_unexpected: got r=%h with nothing outstanding", result8);
        end else begin
          exp_v = q.pop_front();
          if ({result8, cout8, ovf8, zero8} !== exp_v) begin
            fails++;
            $display("FAIL stream_result: got r=%h c=%b o=%b z=%b, need r=%h c=%b o=%b z=%b",
                     result8, cout8, ovf8, zero8, exp_v[10:3], exp_v[2], exp_v[1], exp_v[0]);
          end
        end
      end
      if (in_valid8 && in_ready8) begin
        q.push_back(ref8(a8, b8, binv8, cin8, op8));
        acc++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid8 = 1'b0;
    out_ready8 = 1'b1;
    tests++;
    if (acc != 1000 || q.size() != 0) begin
      fails++;
      $display("FAIL stream_drain: accepted %0d outstanding %0d, need 1000 and 0", acc, q.size());
    end
  endtask

  initial begin
    test_reset();
    test_add_carry();
    test_sub();
    test_slt();
    test_back_to_back();
    test_reset_midflight();
    test_single_stage();
    test_stream8();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_pipe_nbit.md
Name: alu_pipe_nbit

Overview:
- Parametrised, pipelined successor to the team's combinational 8-bit ripple ALU built from 4-bit slices.
- Splits a WIDTH-bit AND/OR/ADD/SLT datapath into WIDTH/SLICE registered slice stages, with the carry passed stage to stage.
- Adds valid/ready flow control, stall support and status flags (zero, carry, overflow).
- Sits between the MIPS register-read stage and writeback, so a wide ALU can close timing at a high clock rate.

Parameters:
- WIDTH, 32, operand/result width in bits.
- SLICE, 8, bits computed per pipeline stage. WIDTH % SLICE != 0 is an elaboration error.
- STAGES, WIDTH/SLICE, derived (localparam); pipeline depth, minimum 1.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand set present.
- in_ready  out  1  pipeline can accept this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- binv  in  1  invert B before the slice logic.
- cin  in  1  carry into slice 0.
- op  in  2  00 AND, 01 OR, 10 ADD, 11 SLT.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- result  out  WIDTH  ALU result.
- zero  out  1  result == 0.
- cout  out  1  carry out of the MSB (ADD/SLT).
- ovf  out  1  signed overflow of the add path.

Behaviour:
- Reset: rst=1 asynchronously clears all stage valid bits and all stage data registers, so out_valid=0, result=0, zero=1, cout=0, ovf=0. in_ready=1 while rst=0 and the pipe is empty. Reset mid-operation discards every in-flight operation with no partial output.
- Advance: advance = !out_valid || out_ready. in_ready = advance. When advance=0, every stage holds; a, b, op and in_valid are ignored that cycle.
- Accept: an operation is accepted on a rising edge where in_valid && in_ready.
- Stage 1: on the accepting edge, computes slice 0 from the live inputs (cin, binv, op) and captures it. It also captures the remaining operand bits, binv, op, the slice carry and valid.
- Stage i: computes slice i-1 from the delayed operands and the carry registered by stage i-1, then captures it. Earlier slice results travel down unchanged.
- Slice function: bb = b ^ {SLICE{binv}}. AND = a & bb; OR = a | bb; ADD and SLT use sum = a + bb + carry_in.
- Latency: counting the accepting edge as edge 1, the result is on the outputs after edge STAGES with out_valid=1. STAGES=1 gives a single-register ALU.
- Throughput: one operation per cycle when out_ready=1. Order is preserved and there are no bubbles unless in_valid=0.
- Final stage, small combinational logic from the last register only:
  - ovf = carry into MSB ^ carry out of MSB.
  - cout = MSB carry out.
  - SLT: result = {WIDTH-1 zeros, sum[MSB] ^ ovf}.
  - zero = (result == 0) on the muxed result.
- Flags for AND/OR: cout=0, ovf=0.
- Subtraction and SLT semantics are the caller's responsibility: binv=1, cin=1.
- Output hold: while out_valid=1 and out_ready=0, result, zero, cout and ovf stay stable.
- Simultaneous events: a final-stage output and an upstream accept in the same cycle are both honoured.
- Wrap-around: ADD is modulo 2^WIDTH, with cout and ovf reporting the overflow.

Decomposition:
- Package alu_pkg: op encodings (OP_AND, OP_OR, OP_ADD, OP_SLT) and the 2-bit op typedef.
- Sub-module alu_slice (parameter SLICE): combinational slice computing AND/OR/sum, carry out and carry into its MSB.
- alu_pipe_nbit instantiates STAGES alu_slice copies with a generate loop, plus the stage registers and the output mux.

Test Plan (WIDTH=32, SLICE=8, STAGES=4 unless stated):
- Reset mid-flight: hold rst=1 with 3 ops in flight, release -> out_valid=0 for 4 cycles and no stale result appears. result=0 and zero=1 during reset.
- ADD with carry chain: a=0x00FF_FFFF, b=0x0000_0001, op=ADD, binv=0, cin=0, accepted on edge 1 -> out_valid after edge 4, result=0x0100_0000, cout=0, ovf=0, zero=0.
- SUB, overflow and zero:
  - a=0x8000_0000, b=1, binv=1, cin=1, op=ADD -> result=0x7FFF_FFFF, ovf=1, cout=1.
  - a=b=0x1234_5678 -> result=0, zero=1.
- SLT:
  - a=0xFFFF_FFFF (-1), b=1, binv=1, cin=1 -> result=1.
  - a=0x7FFF_FFFF, b=0x8000_0000 -> result=0, with ovf=1 handled correctly.
- Back-to-back with stall: issue AND (0xF0F0_F0F0 & 0xFF00_FF00 = 0xF000_F000) and OR (result 0xFFF0_FFF0) on consecutive cycles. Drop out_ready for 3 cycles once out_valid=1 -> in_ready=0 during the stall, the AND result is held stable, both results delivered in order, no loss or duplication.
- STAGES=1 build (WIDTH=8, SLICE=8): a=0x7F, b=0x01, ADD -> result=0x80, ovf=1 one edge after accept. Random streaming of 1000 ops checked against a reference model.
